// File: rtl/capture_ctrl_if.sv
// Command, sample-RAM and transmitter signals of the capture controller.
// The controller connects through slave; the surrounding logic connects through master.
interface capture_ctrl_if #(
    parameter int unsigned SMPL_WIDTH = 32,
    parameter int unsigned TX_WIDTH   = 8,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned CNT_WIDTH  = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                    set_cnt_i;
    logic [2*CNT_WIDTH-1:0]  cnt_i;
    logic                    arm_i;
    logic                    abort_i;
    logic                    trg_i;
    logic                    stb_i;
    logic [SMPL_WIDTH-1:0]   smpls_i;
    logic [AW-1:0]           mem_addr_o;
    logic                    mem_we_o;
    logic [SMPL_WIDTH-1:0]   mem_wdata_o;
    logic [SMPL_WIDTH-1:0]   mem_rdata_i;
    logic                    tx_rdy_i;
    logic                    tx_stb_o;
    logic [TX_WIDTH-1:0]     tx_o;
    logic                    busy_o;
    logic                    done_o;

    modport slave (
        input  set_cnt_i, cnt_i, arm_i, abort_i, trg_i, stb_i, smpls_i,
               mem_rdata_i, tx_rdy_i,
        output mem_addr_o, mem_we_o, mem_wdata_o, tx_stb_o, tx_o, busy_o, done_o
    );

    modport master (
        output set_cnt_i, cnt_i, arm_i, abort_i, trg_i, stb_i, smpls_i,
               mem_rdata_i, tx_rdy_i,
        input  mem_addr_o, mem_we_o, mem_wdata_o, tx_stb_o, tx_o, busy_o, done_o
    );
endinterface

// File: rtl/capture_ctrl.sv
// Logic-analyser capture/readout controller: ring-buffer capture with pre/post trigger,
// then newest-first readout of the stored samples in TX_WIDTH chunks.
module capture_ctrl #(
    parameter int unsigned SMPL_WIDTH = 32,
    parameter int unsigned TX_WIDTH   = 8,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    capture_ctrl_if.slave bus
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned RW     = CNT_WIDTH + 1;
    localparam int unsigned CHUNKS = SMPL_WIDTH / TX_WIDTH;
    localparam int unsigned CW     = $clog2(CHUNKS + 1);

    typedef enum logic [2:0] {
        IDLE, ARMED, POST, RD_REQ, RD_WAIT, TX_CHUNK, TX_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  dly_cnt_q, dly_cnt_d;
    logic [RW-1:0]         post_cnt_q, post_cnt_d;
    logic [RW-1:0]         remain_q, remain_d;
    logic [SMPL_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         chunk_q, chunk_d;
    logic                  wait_first_q, wait_first_d;
    logic                  tx_stb_q, tx_stb_d;
    logic [TX_WIDTH-1:0]   tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [RW-1:0]         rem_full;
    logic [RW-1:0]         rem_init;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '1;
            dly_cnt_q    <= '0;
            post_cnt_q   <= '0;
            remain_q     <= '0;
            shift_q      <= '0;
            chunk_q      <= '0;
            wait_first_q <= 1'b0;
            tx_stb_q     <= 1'b0;
            tx_q         <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            dly_cnt_q    <= dly_cnt_d;
            post_cnt_q   <= post_cnt_d;
            remain_q     <= remain_d;
            shift_q      <= shift_d;
            chunk_q      <= chunk_d;
            wait_first_q <= wait_first_d;
            tx_stb_q     <= tx_stb_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        dly_cnt_d    = dly_cnt_q;
        post_cnt_d   = post_cnt_q;
        remain_d     = remain_q;
        shift_d      = shift_q;
        chunk_d      = chunk_q;
        wait_first_d = wait_first_q;
        tx_stb_d     = 1'b0;
        tx_d         = tx_q;
        done_d       = 1'b0;

        // Extra count bit keeps rd_cnt = all ones from wrapping before the clamp
        rem_full = RW'(rd_cnt_q) + RW'(1);
        rem_init = (rem_full > RW'(DEPTH)) ? RW'(DEPTH) : rem_full;

        case (state_q)
            IDLE: begin
                if (bus.set_cnt_i) begin
                    rd_cnt_d  = bus.cnt_i[2*CNT_WIDTH-1:CNT_WIDTH];
                    dly_cnt_d = bus.cnt_i[CNT_WIDTH-1:0];
                end
                if (bus.arm_i) state_d = ARMED;
            end
            ARMED: begin
                if (bus.stb_i) wr_ptr_d = wr_ptr_q + AW'(1);
                if (bus.trg_i) begin
                    post_cnt_d = '0;
                    state_d    = POST;
                end
            end
            POST: begin
                if (bus.stb_i) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (post_cnt_q == RW'(dly_cnt_q)) begin
                        rd_ptr_d = wr_ptr_q;
                        remain_d = rem_init;
                        state_d  = RD_REQ;
                    end else begin
                        post_cnt_d = post_cnt_q + RW'(1);
                    end
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                shift_d = bus.mem_rdata_i;
                chunk_d = '0;
                state_d = TX_CHUNK;
            end
            TX_CHUNK: begin
                if (bus.tx_rdy_i) begin
                    tx_stb_d     = 1'b1;
                    tx_d         = shift_q[TX_WIDTH-1:0];
                    shift_d      = shift_q >> TX_WIDTH;
                    chunk_d      = chunk_q + CW'(1);
                    wait_first_d = 1'b1;
                    state_d      = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The transmitter's ready still reflects the pre-strobe cycle here
                wait_first_d = 1'b0;
                if (!wait_first_q && bus.tx_rdy_i) begin
                    if (chunk_q != CW'(CHUNKS)) begin
                        state_d = TX_CHUNK;
                    end else begin
                        remain_d = remain_q - RW'(1);
                        rd_ptr_d = rd_ptr_q - AW'(1);
                        if (remain_q == RW'(1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort_i) begin
            state_d  = IDLE;
            tx_stb_d = 1'b0;
            tx_d     = tx_q;
            done_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.mem_we_o    = bus.stb_i && ((state_q == ARMED) || (state_q == POST));
    assign bus.mem_addr_o  = (state_q == RD_REQ) ? rd_ptr_q : wr_ptr_q;
    assign bus.mem_wdata_o = bus.smpls_i;
    assign bus.tx_stb_o    = tx_stb_q;
    assign bus.tx_o        = tx_q;
    assign bus.done_o      = done_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: RAM and transmitter models, expected writes and
// transmitted chunks queued at stimulus time and compared as the controller produces them.
module tb_capture_ctrl;
    localparam int unsigned SW = 32;
    localparam int unsigned TW = 8;
    localparam int unsigned DP = 16;
    localparam int unsigned CN = 16;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic bp_hold;

    capture_ctrl_if #(.SMPL_WIDTH(SW), .TX_WIDTH(TW), .DEPTH(DP), .CNT_WIDTH(CN)) bus ();

    capture_ctrl #(.SMPL_WIDTH(SW), .TX_WIDTH(TW), .DEPTH(DP), .CNT_WIDTH(CN)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    logic [31:0] ram    [DP];
    logic [31:0] shadow [DP];
    logic [3:0]  exp_wr_ptr;
    logic [3:0]  last_wr_addr;
    wr_t         exp_wr [$];
    logic [7:0]  exp_tx [$];
    int n_checks, n_pass, tx_seen, done_seen, exp_done, hold_stb, tx_busy;

    always #5 clk_i = ~clk_i;

    // Sample RAM with one-cycle read latency
    always @(posedge clk_i) begin
        if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
        bus.mem_rdata_i <= ram[bus.mem_addr_o];
    end

    // Transmitter: busy for 3 cycles after each strobe
    always @(negedge clk_i) begin
        if (rst_i)                tx_busy <= 0;
        else if (bus.tx_stb_o)    tx_busy <= 3;
        else if (tx_busy != 0)    tx_busy <= tx_busy - 1;
    end
    assign bus.tx_rdy_i = (tx_busy == 0) && !bp_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic monitor();
        wr_t w;
        if (!rst_i) begin
            if (bus.mem_we_o) begin
                last_wr_addr = bus.mem_addr_o;
                if (exp_wr.size() == 0) check("wr_extra", 32'(exp_wr.size()), 32'd1);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.mem_addr_o), 32'(w.addr));
                    check("wr_data", bus.mem_wdata_o, w.data);
                end
            end
            if (bus.tx_stb_o) begin
                tx_seen++;
                if (bp_hold) hold_stb++;
                if (exp_tx.size() == 0) check("tx_extra", 32'(exp_tx.size()), 32'd1);
                else check("tx_data", 32'(bus.tx_o), 32'(exp_tx.pop_front()));
            end
            if (bus.done_o) done_seen++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(bus.busy_o),     32'd0);
        check({tag, "_txstb"},  32'(bus.tx_stb_o),   32'd0);
        check({tag, "_tx"},     32'(bus.tx_o),       32'd0);
        check({tag, "_done"},   32'(bus.done_o),     32'd0);
        check({tag, "_we"},     32'(bus.mem_we_o),   32'd0);
        check({tag, "_addr"},   32'(bus.mem_addr_o), 32'd0);
    endtask

    task automatic set_cnt(input logic [31:0] v);
        bus.set_cnt_i = 1'b1;
        bus.cnt_i     = v;
        tick();
        bus.set_cnt_i = 1'b0;
    endtask

    task automatic arm();
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
    endtask

    task automatic trig();
        bus.trg_i = 1'b1;
        tick();
        bus.trg_i = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] d);
        bus.stb_i   = 1'b1;
        bus.smpls_i = d;
        exp_wr.push_back('{addr: exp_wr_ptr, data: d});
        shadow[exp_wr_ptr] = d;
        exp_wr_ptr++;
        tick();
        bus.stb_i = 1'b0;
    endtask

    // Newest-first readout of n samples, least-significant chunk first
    task automatic expect_readout(input int n, input bit with_done);
        logic [3:0]  a;
        logic [31:0] d;
        a = exp_wr_ptr - 4'd1;
        for (int k = 0; k < n; k++) begin
            d = shadow[a];
            for (int c = 0; c < 4; c++) exp_tx.push_back(d[c*8 +: 8]);
            a = a - 4'd1;
        end
        if (with_done) exp_done++;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int cyc;
        cyc = 0;
        while (tx_seen < n && cyc < 500) begin
            @(negedge clk_i);
            cyc++;
        end
        check(tag, 32'(tx_seen >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (bus.busy_o && cyc < 3000) begin
            tick();
            cyc++;
        end
        tick();
        check({tag, "_idle"},    32'(bus.busy_o),     32'd0);
        check({tag, "_tx_left"}, 32'(exp_tx.size()),  32'd0);
        check({tag, "_wr_left"}, 32'(exp_wr.size()),  32'd0);
        check({tag, "_done"},    32'(done_seen),      32'(exp_done));
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : main
        int base;
        n_checks = 0; n_pass = 0; tx_seen = 0; done_seen = 0; exp_done = 0; hold_stb = 0;
        rst_i = 1'b1; bp_hold = 1'b0; exp_wr_ptr = '0; last_wr_addr = '0;
        bus.set_cnt_i = 1'b0; bus.cnt_i = '0; bus.arm_i = 1'b0; bus.abort_i = 1'b0;
        bus.trg_i = 1'b0; bus.stb_i = 1'b0; bus.smpls_i = '0;
        fork
            forever begin
                @(negedge clk_i);
                monitor();
            end
        join_none

        repeat (3) tick();
        check_reset_outputs("rst");
        rst_i = 1'b0;
        tick();

        // Basic capture: 6 pre-trigger, 4 post-trigger, read 5 newest
        set_cnt(32'h0004_0003);
        arm();
        check("armed_busy", 32'(bus.busy_o), 32'd1);
        for (int i = 1; i <= 6; i++) strobe(32'(i));
        trig();
        for (int i = 7; i <= 10; i++) strobe(32'(i));
        expect_readout(5, 1'b1);
        wait_idle("basic");

        // Count load while armed and re-arm while in POST must be ignored
        arm();
        set_cnt(32'h0001_0001);
        for (int i = 11; i <= 13; i++) strobe(32'(i));
        trig();
        arm();
        for (int i = 14; i <= 17; i++) strobe(32'(i));
        expect_readout(5, 1'b1);
        wait_idle("ignored");

        // Backpressure: ready held low for 10 cycles in the middle of a sample
        arm();
        strobe(32'h0000_0A14); strobe(32'h0000_0B15);
        trig();
        for (int i = 0; i < 4; i++) strobe(32'h1234_5600 + 32'(i));
        expect_readout(5, 1'b1);
        base = tx_seen;
        wait_tx(base + 2, "bp_wait");
        hold_stb = 0;
        bp_hold  = 1'b1;
        repeat (10) tick();
        bp_hold = 1'b0;
        check("bp_no_stb", 32'(hold_stb), 32'd0);
        wait_idle("bp");

        // Abort during the second TX_WAIT
        arm();
        strobe(32'h0000_001E); strobe(32'h0000_001F);
        trig();
        for (int i = 32; i <= 35; i++) strobe(32'hAB00_0000 + 32'(i));
        expect_readout(5, 1'b0);
        base = tx_seen;
        wait_tx(base + 2, "abort_wait");
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_txstb", 32'(bus.tx_stb_o), 32'd0);
        check("abort_sent", 32'(tx_seen - base), 32'd2);
        exp_tx.delete();
        repeat (30) tick();
        check("abort_no_more_tx", 32'(tx_seen - base), 32'd2);
        check("abort_no_done", 32'(done_seen), 32'(exp_done));

        // Capture after abort, then reset in the middle of the readout
        arm();
        strobe(32'h0000_0028); strobe(32'h0000_0029);
        trig();
        for (int i = 42; i <= 45; i++) strobe(32'hCD00_0000 + 32'(i));
        expect_readout(5, 1'b0);
        base = tx_seen;
        wait_tx(base + 5, "rst_wait");
        check("rst_wait_busy", 32'(bus.busy_o), 32'd1);
        rst_i = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst_i = 1'b0;
        exp_tx.delete();
        exp_wr_ptr = '0;
        tick();

        // Reset counts (read all ones, delay 0): wrap the ring, read clamped to DEPTH
        arm();
        for (int i = 0; i <= 19; i++) strobe(pat(i));
        trig();
        strobe(pat(20));
        check("wrap_last_addr", 32'(last_wr_addr), 32'd4);
        expect_readout(16, 1'b1);
        wait_idle("wrap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Parametrised capture/readout controller for the logic analyser core.
- Owns ring-buffer addressing for the sample RAM, with pre-trigger capture, a programmable post-trigger delay and a programmable readout count.
- Streams stored samples newest-first to the UART transmitter, split into TX_WIDTH chunks.
- Sits between the command decoder/trigger unit and the sample RAM and transmitter.

Parameters:
- SMPL_WIDTH, 32, bits per sample; must be an integer multiple of TX_WIDTH.
- TX_WIDTH, 8, bits per transmitter transfer.
- DEPTH, 1024, sample RAM words; power of two, at least 2. AW = log2(DEPTH).
- CNT_WIDTH, 16, width of each count field in cnt_i.

Ports:
- clk_i  in  1  system clock; one clock domain only.
- rst_i  in  1  synchronous, active-high reset.
- set_cnt_i  in  1  load counts from cnt_i.
- cnt_i  in  2*CNT_WIDTH  [2*CNT_WIDTH-1:CNT_WIDTH] = rd_cnt, [CNT_WIDTH-1:0] = dly_cnt.
- arm_i  in  1  start capture.
- abort_i  in  1  return to IDLE.
- trg_i  in  1  trigger hit.
- stb_i  in  1  sample valid.
- smpls_i  in  SMPL_WIDTH  sample data.
- mem_addr_o  out  AW  RAM address.
- mem_we_o  out  1  RAM write enable.
- mem_wdata_o  out  SMPL_WIDTH  RAM write data; equals smpls_i.
- mem_rdata_i  in  SMPL_WIDTH  RAM read data; 1-cycle latency.
- tx_rdy_i  in  1  transmitter idle.
- tx_stb_o  out  1  transmit pulse.
- tx_o  out  TX_WIDTH  transmit data.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse after the last chunk is accepted.

Behaviour:
- Reset: state IDLE; wr_ptr=0; rd_cnt=all ones; dly_cnt=0.
- Reset values on outputs: tx_stb_o=0, tx_o=0, mem_we_o=0, busy_o=0, done_o=0, mem_addr_o=0.
- Reset overrides all inputs, including in mid-operation.
- States: IDLE, ARMED, POST, RD_REQ, RD_WAIT, TX_CHUNK, TX_WAIT.
- IDLE:
  - set_cnt_i loads rd_cnt and dly_cnt.
  - arm_i -> ARMED.
  - set_cnt_i is ignored in every other state; arm_i is ignored outside IDLE.
- ARMED:
  - mem_we_o = stb_i; mem_addr_o = wr_ptr; wr_ptr increments mod DEPTH on each stb_i.
  - trg_i -> POST, with post counter = 0.
  - A sample strobed in the same cycle as trg_i is written and counts as pre-trigger.
- POST:
  - Same write behaviour as ARMED; each stb_i increments the post counter.
  - When the (dly_cnt+1)-th post-trigger sample is written -> RD_REQ.
  - On that transition: rd_ptr = wr_ptr_next-1 (the newest sample); remaining = min(rd_cnt+1, DEPTH).
  - trg_i is ignored in POST.
- RD_REQ: mem_addr_o = rd_ptr; next cycle -> RD_WAIT.
- RD_WAIT: capture mem_rdata_i into the shift register; chunk index = 0 -> TX_CHUNK.
- TX_CHUNK:
  - While tx_rdy_i=1: tx_stb_o=1 for exactly one cycle; tx_o = shift[TX_WIDTH-1:0]; shift right by TX_WIDTH -> TX_WAIT.
  - tx_o holds its value until the next strobe.
- TX_WAIT:
  - tx_rdy_i is ignored in the first cycle; after that, wait for tx_rdy_i=1.
  - If chunks remain in the sample -> TX_CHUNK.
  - Else decrement remaining and rd_ptr (mod DEPTH).
  - If remaining reaches 0: done_o pulse -> IDLE. Otherwise -> RD_REQ.
- Chunks per sample = SMPL_WIDTH/TX_WIDTH, least-significant chunk first.
- Read-phase data is not tied to capture history: if fewer samples were captured than requested, stale RAM content is sent, but the number of chunks sent is still exact.
- abort_i, in any state: IDLE on the next cycle. tx_stb_o is not asserted in that cycle; no done_o. wr_ptr is retained.
- mem_we_o is 0 outside ARMED/POST. mem_addr_o = wr_ptr in IDLE.
- Counter arithmetic uses CNT_WIDTH+1 bits, so rd_cnt = all ones does not overflow; the count is then clamped to DEPTH.

Test Plan (DEPTH=16, SMPL_WIDTH=32, TX_WIDTH=8, tx_rdy_i returns 3 cycles after each strobe unless stated):
- Reset check: assert rst_i mid-TX -> next cycle all outputs 0 and busy_o=0; rd_cnt=0xFFFF and dly_cnt=0 are verified via a subsequent capture.
- Basic capture:
  - Stimulus: cnt_i=0x0004_0003; arm; strobe samples 1..6; trg (no strobe); strobe 7..10.
  - Response: RD_REQ after sample 10. tx_o sequence is 0x0A,0,0,0, 0x09,0,0,0 … 0x06,0,0,0 (20 strobes), then one done_o.
- Wrap/clamp:
  - Stimulus: cnt_i=0xFFFF_0000; samples 0..19 pre-trigger; trg; sample 20.
  - Response: sample 20 written at address 4; exactly 16 samples sent, 20 down to 5; addresses read 4,3,…,0,15,…,5.
- Backpressure: hold tx_rdy_i=0 for 10 cycles mid-sample -> tx_stb_o stays 0 throughout; no chunk is dropped or duplicated, and the chunk sequence is unchanged.
- Abort: abort_i during the second TX_WAIT -> IDLE on the next cycle; no further tx_stb_o; no done_o; a subsequent arm captures normally.
- Ignored commands: set_cnt_i with 0x0001_0001 while ARMED, and arm_i while in POST -> no effect; the original counts are still used (readout = 5 samples for cnt 0x0004_0003).
